// File: rtl/analyzer_pkg.sv
// Shared types and helpers for the trace-buffer capture/readback pair.
package analyzer_pkg;

  localparam int unsigned ADDR_W_DEF = 25;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRETRIG  = 2'd1,
    POSTTRIG = 2'd2
  } cap_state_e;

  // Increment a sample number modulo 2^aw (aw <= 32).
  function automatic logic [31:0] wrap_inc(input logic [31:0] v, input int unsigned aw);
    logic [31:0] mask;
    mask = (aw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << aw) - 32'd1);
    return (v + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/analyzer_capture_fsm_if.sv
// Trace RAM write port: capture side drives the request, RAM side grants it.
interface analyzer_capture_fsm_if
  import analyzer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              write_req;
  logic [31:0]       writeSampleNumber;
  logic [DATA_W-1:0] write_data;
  logic              write_allowed;

  modport master (output write_req, writeSampleNumber, write_data, input write_allowed);
  modport slave  (input write_req, writeSampleNumber, write_data, output write_allowed);
endinterface

// File: rtl/analyzer_write_slot.sv
// Single-entry output register toward the trace RAM with sticky overrun detection.
module analyzer_write_slot
  import analyzer_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  input  logic              flush,
  input  logic              clr_overrun,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              load_tag,
  input  logic              write_allowed,
  output logic              load_c,
  output logic              done_c,
  output logic              write_req,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              write_tag,
  output logic              overrun
);

  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              tag_q, tag_d;
  logic              ovr_q, ovr_d;
  logic              drop_c;

  // A slot that completes this cycle counts as free, giving back-to-back writes.
  always_comb begin
    req_d  = req_q;
    addr_d = addr_q;
    data_d = data_q;
    tag_d  = tag_q;
    done_c = req_q && write_allowed;
    load_c = active && sample_valid && (!req_q || done_c);
    drop_c = active && !flush && sample_valid && req_q && !write_allowed;
    if (done_c) req_d = 1'b0;
    if (load_c) begin
      req_d  = 1'b1;
      addr_d = load_addr;
      data_d = sample_data;
      tag_d  = load_tag;
    end
    if (flush) req_d = 1'b0;
    ovr_d = clr_overrun ? 1'b0 : (ovr_q | drop_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      tag_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      req_q  <= req_d;
      addr_q <= addr_d;
      data_q <= data_d;
      tag_q  <= tag_d;
      ovr_q  <= ovr_d;
    end
  end

  assign write_req  = req_q;
  assign write_addr = addr_q;
  assign write_data = data_q;
  assign write_tag  = tag_q;
  assign overrun    = ovr_q;

endmodule

// File: rtl/analyzer_capture_fsm.sv
// Trace capture FSM: streams samples into a circular RAM around a trigger and
// publishes the inclusive stored-sample window for readback.
module analyzer_capture_fsm
  import analyzer_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   trigger,
  input  logic                   sample_valid,
  input  logic [DATA_W-1:0]      sample_data,
  input  logic [31:0]            post_trigger_count,
  analyzer_capture_fsm_if.master wr,
  output logic                   idle,
  output logic                   triggered,
  output logic                   overrun,
  output logic                   capture_valid,
  output logic [31:0]            sampleNumber_Begin,
  output logic [31:0]            sampleNumber_End
);

  localparam int unsigned FILL_W = ADDR_W + 1;

  cap_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [31:0]       post_q, post_d;
  logic              pend_trig_q, pend_trig_d;
  logic              triggered_q, triggered_d;
  logic              cv_q, cv_d;
  logic              idle_q, idle_d;
  logic [ADDR_W-1:0] begin_q, begin_d;
  logic [ADDR_W-1:0] end_q, end_d;

  logic              active_c, flush_c, clr_ovr_c, finish_c;
  logic [ADDR_W-1:0] load_addr_c;
  logic              load_tag_c;
  logic              load_c, done_c;
  logic              slot_req, slot_tag, slot_ovr;
  logic [ADDR_W-1:0] slot_addr;
  logic [DATA_W-1:0] slot_data;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return ADDR_W'(wrap_inc(32'(p), ADDR_W));
  endfunction

  analyzer_write_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
    .clk          (clk),
    .reset        (reset),
    .active       (active_c),
    .flush        (flush_c),
    .clr_overrun  (clr_ovr_c),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .load_addr    (load_addr_c),
    .load_tag     (load_tag_c),
    .write_allowed(wr.write_allowed),
    .load_c       (load_c),
    .done_c       (done_c),
    .write_req    (slot_req),
    .write_addr   (slot_addr),
    .write_data   (slot_data),
    .write_tag    (slot_tag),
    .overrun      (slot_ovr)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    post_d      = post_q;
    pend_trig_d = pend_trig_q;
    triggered_d = triggered_q;
    cv_d        = cv_q;
    begin_d     = begin_q;
    end_d       = end_q;
    flush_c     = 1'b0;
    clr_ovr_c   = 1'b0;
    finish_c    = 1'b0;
    active_c    = (state_q != IDLE);
    // A reload in the completion cycle takes the address after the one retiring.
    load_addr_c = done_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    load_tag_c  = (state_q == PRETRIG) && (trigger || pend_trig_q);

    if (done_c) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
      if (!fill_q[ADDR_W]) fill_d = fill_q + FILL_W'(1);
    end
    if (load_tag_c) pend_trig_d = !load_c;

    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d     = PRETRIG;
          wr_ptr_d    = '0;
          fill_d      = '0;
          post_d      = post_trigger_count;
          clr_ovr_c   = 1'b1;
          triggered_d = 1'b0;
          pend_trig_d = 1'b0;
          cv_d        = 1'b0;
        end
      end
      PRETRIG: begin
        if (done_c && slot_tag) begin
          triggered_d = 1'b1;
          if (post_q == 32'd0) finish_c = 1'b1;
          else                 state_d  = POSTTRIG;
        end
      end
      POSTTRIG: begin
        if (done_c) begin
          post_d = post_q - 32'd1;
          if (post_q <= 32'd1) finish_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Window is inclusive; a full buffer starts just after the newest sample.
    if (finish_c) begin
      state_d = IDLE;
      flush_c = 1'b1;
      cv_d    = 1'b1;
      end_d   = slot_addr;
      begin_d = fill_d[ADDR_W] ? ptr_inc(slot_addr) : '0;
    end
    if (abort) begin
      state_d = IDLE;
      flush_c = 1'b1;
      cv_d    = 1'b0;
      begin_d = begin_q;
      end_d   = end_q;
    end
    idle_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      post_q      <= '0;
      pend_trig_q <= 1'b0;
      triggered_q <= 1'b0;
      cv_q        <= 1'b0;
      idle_q      <= 1'b1;
      begin_q     <= '0;
      end_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      post_q      <= post_d;
      pend_trig_q <= pend_trig_d;
      triggered_q <= triggered_d;
      cv_q        <= cv_d;
      idle_q      <= idle_d;
      begin_q     <= begin_d;
      end_q       <= end_d;
    end
  end

  assign wr.write_req         = slot_req;
  assign wr.writeSampleNumber = 32'(slot_addr);
  assign wr.write_data        = slot_data;
  assign idle                 = idle_q;
  assign triggered            = triggered_q;
  assign overrun              = slot_ovr;
  assign capture_valid        = cv_q;
  assign sampleNumber_Begin   = 32'(begin_q);
  assign sampleNumber_End     = 32'(end_q);

endmodule

// File: tb/tb_analyzer_capture_fsm.sv
// Bench for analyzer_capture_fsm: scenario table, randomized captures, and
// hand-written abort/reset sequences, all checked against a queue-based model.
module tb_analyzer_capture_fsm;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int          DEPTH = 16;
  localparam int          BUDGET = 600;

  logic        clk = 1'b0;
  logic        reset, arm, abort, trigger, sample_valid;
  logic [31:0] sample_data, post_trigger_count;
  logic        idle, triggered, overrun, capture_valid;
  logic [31:0] sb, se;

  analyzer_capture_fsm_if #(.DATA_W(DW)) wr_if ();

  analyzer_capture_fsm #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk               (clk),
    .reset             (reset),
    .arm               (arm),
    .abort             (abort),
    .trigger           (trigger),
    .sample_valid      (sample_valid),
    .sample_data       (sample_data),
    .post_trigger_count(post_trigger_count),
    .wr                (wr_if),
    .idle              (idle),
    .triggered         (triggered),
    .overrun           (overrun),
    .capture_valid     (capture_valid),
    .sampleNumber_Begin(sb),
    .sampleNumber_End  (se)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int nwr_obs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the output slot is a queue of at most one pending write.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          tag;
  } wr_t;

  wr_t         m_q[$];
  int          m_mode;
  int unsigned m_post;
  bit          m_pend, m_trig, m_ovr, m_cv;
  int          m_ptr, m_fill, m_begin, m_end, m_nwr;

  task automatic model_reset();
    m_q.delete();
    m_mode = 0; m_post = 0; m_pend = 0; m_trig = 0; m_ovr = 0; m_cv = 0;
    m_ptr = 0; m_fill = 0; m_begin = 0; m_end = 0; m_nwr = 0;
  endtask

  task automatic model_step(input bit a, input bit ab, input bit tg, input bit sv,
                            input logic [31:0] sd, input logic [31:0] ptc, input bit alw);
    wr_t w;
    bit  fin, loaded, tagnow;
    int  newmode;
    if (ab) begin
      m_mode = 0; m_q.delete(); m_cv = 0;
      return;
    end
    if (m_mode == 0) begin
      if (a) begin
        m_mode = 1; m_ptr = 0; m_fill = 0; m_post = ptc; m_ovr = 0;
        m_trig = 0; m_pend = 0; m_cv = 0; m_nwr = 0;
      end
      return;
    end
    fin = 0; loaded = 0; newmode = m_mode;
    tagnow = (m_mode == 1) && (tg || m_pend);
    if (m_q.size() > 0 && alw) begin
      w = m_q.pop_front();
      m_nwr++;
      m_ptr = (m_ptr + 1) % DEPTH;
      if (m_fill < DEPTH) m_fill++;
      if (m_mode == 1) begin
        if (w.tag) begin
          m_trig = 1;
          if (m_post == 0) fin = 1; else newmode = 2;
        end
      end else begin
        m_post--;
        if (m_post == 0) fin = 1;
      end
    end
    if (sv) begin
      if (m_q.size() == 0) begin
        m_q.push_back('{32'(m_ptr), sd, tagnow});
        loaded = 1;
      end else m_ovr = 1;
    end
    if (tagnow) m_pend = !loaded;
    m_mode = newmode;
    if (fin) begin
      m_mode = 0; m_q.delete(); m_cv = 1;
      m_end   = int'(w.addr);
      m_begin = (m_fill >= DEPTH) ? (m_end + 1) % DEPTH : 0;
    end
  endtask

  task automatic check_outputs();
    chk("idle", 32'(idle), 32'(m_mode == 0));
    chk("write_req", 32'(wr_if.write_req), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("write_addr", wr_if.writeSampleNumber, m_q[0].addr);
      chk("write_data", wr_if.write_data, m_q[0].data);
    end
    chk("triggered", 32'(triggered), 32'(m_trig));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("capture_valid", 32'(capture_valid), 32'(m_cv));
    chk("begin", sb, 32'(m_begin));
    chk("end", se, 32'(m_end));
  endtask

  task automatic cycle(input bit a, input bit ab, input bit tg, input bit sv,
                       input logic [31:0] ptc, input bit alw);
    logic [31:0] sd;
    sd = $urandom;
    arm = a; abort = ab; trigger = tg; sample_valid = sv;
    sample_data = sd; post_trigger_count = ptc; wr_if.write_allowed = alw;
    if (wr_if.write_req && alw) nwr_obs++;
    model_step(a, ab, tg, sv, sd, ptc, alw);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1; arm = 0; abort = 0; trigger = 0; sample_valid = 0;
    sample_data = 32'hA5A5_5A5A; post_trigger_count = 0; wr_if.write_allowed = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_write_req", 32'(wr_if.write_req), 32'd0);
    chk("rst_write_addr", wr_if.writeSampleNumber, 32'd0);
    chk("rst_write_data", wr_if.write_data, 32'd0);
    chk("rst_triggered", 32'(triggered), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_capture_valid", 32'(capture_valid), 32'd0);
    chk("rst_begin", sb, 32'd0);
    chk("rst_end", se, 32'd0);
  endtask

  // vmode: 0 valid every cycle, 1 every other cycle, 2 every other cycle with the
  // trigger pulsed on the empty cycle before the target sample.
  // amode: 0 always allowed, 1 random on empty cycles, 2 low for first two cycles, 3 random.
  task automatic run_capture(input int trig_idx, input int post, input int vmode, input int amode);
    int s, c;
    bit sv, tg, alw;
    nwr_obs = 0;
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'(post), 1'b1);
    s = 0; c = 0;
    while (m_mode != 0 && c < BUDGET) begin
      sv = (vmode == 0) ? 1'b1 : (c % 2 == 0);
      if (vmode == 2) tg = !sv && (s == trig_idx);
      else            tg = sv && (s == trig_idx);
      case (amode)
        0:       alw = 1'b1;
        1:       alw = sv ? 1'b1 : 1'($urandom % 2);
        2:       alw = (c >= 2);
        default: alw = ($urandom % 4) != 0;
      endcase
      cycle(1'b0, 1'b0, tg, sv, 32'(post), alw);
      if (sv) s++;
      c++;
    end
    chk("capture_within_budget", 32'(c < BUDGET), 32'd1);
  endtask

  typedef struct {
    int trig_idx;
    int post;
    int vmode;
    int amode;
    int exp_writes;
    int exp_begin;
    int exp_end;
    int exp_ovr;
  } vec_t;

  vec_t tab[8];

  initial begin
    tab[0] = '{2,  5,  0, 0, 8,  0,  7,  0};  // basic
    tab[1] = '{4,  0,  0, 0, 5,  0,  4,  0};  // exit on trigger write
    tab[2] = '{17, 0,  0, 0, 18, 2,  1,  0};  // exit on trigger write, wrapped
    tab[3] = '{10, 5,  0, 0, 16, 0,  15, 0};  // exactly full
    tab[4] = '{12, 17, 1, 1, 30, 14, 13, 0};  // random backpressure, no drops
    tab[5] = '{3,  4,  2, 0, 8,  0,  7,  0};  // pending trigger
    tab[6] = '{3,  2,  0, 2, 5,  0,  4,  1};  // one sample dropped
    tab[7] = '{20, 3,  0, 0, 24, 8,  7,  0};  // wrap, Begin > End

    do_reset();

    foreach (tab[i]) begin
      run_capture(tab[i].trig_idx, tab[i].post, tab[i].vmode, tab[i].amode);
      chk($sformatf("vec%0d_writes", i), 32'(nwr_obs), 32'(tab[i].exp_writes));
      chk($sformatf("vec%0d_begin", i), sb, 32'(tab[i].exp_begin));
      chk($sformatf("vec%0d_end", i), se, 32'(tab[i].exp_end));
      chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(tab[i].exp_ovr));
      chk($sformatf("vec%0d_triggered", i), 32'(triggered), 32'd1);
      chk($sformatf("vec%0d_capture_valid", i), 32'(capture_valid), 32'd1);
      chk($sformatf("vec%0d_idle", i), 32'(idle), 32'd1);
    end

    // Abort in POSTTRIG keeps the previous window.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd10, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'd10, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd10, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd10, 1'b1);
    chk("posttrig_triggered", 32'(triggered), 32'd1);
    chk("posttrig_idle", 32'(idle), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'd10, 1'b0);
    chk("abort_idle", 32'(idle), 32'd1);
    chk("abort_capture_valid", 32'(capture_valid), 32'd0);
    chk("abort_write_req", 32'(wr_if.write_req), 32'd0);
    chk("abort_begin", sb, 32'd8);
    chk("abort_end", se, 32'd7);

    // Reset mid-PRETRIG with a pending write and a sticky overrun.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 1'b0);
    chk("prereset_write_req", 32'(wr_if.write_req), 32'd1);
    chk("prereset_overrun", 32'(overrun), 32'd1);
    do_reset();

    // Randomized captures with unconstrained backpressure.
    for (int r = 0; r < 6; r++) begin
      int tr, po, vm;
      tr = int'($urandom_range(0, 30));
      po = int'($urandom_range(0, 20));
      vm = int'($urandom_range(0, 2));
      run_capture(tr, po, vm, 3);
      chk($sformatf("rand%0d_writes", r), 32'(nwr_obs), 32'(m_nwr));
      chk($sformatf("rand%0d_idle", r), 32'(idle), 32'd1);
      chk($sformatf("rand%0d_capture_valid", r), 32'(capture_valid), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/analyzer_capture_fsm.md
Name: analyzer_capture_fsm

Overview:
- Write side of the trace buffer; the counterpart of analyzerReadbackFSM.
- Once armed, it streams qualified samples into a circular trace RAM and waits for a trigger. After the trigger it stores a programmed number of post-trigger samples, then returns to idle.
- On return to idle it publishes the inclusive sample-number window. analyzerReadbackFSM consumes that window through its idle, sampleNumber_Begin and sampleNumber_End inputs.

Parameters:
- ADDR_W, 25, log2 of trace depth; sample numbers wrap modulo 2^ADDR_W.
- DATA_W, 32, width of one sample word.

Ports:
- clk  input  1  single system clock.
- reset  input  1  synchronous, active-high reset.
- arm  input  1  one-cycle pulse; starts a capture when idle.
- abort  input  1  returns to IDLE from any state.
- trigger  input  1  trigger condition, sampled every cycle.
- sample_valid  input  1  sample_data is a new sample this cycle.
- sample_data  input  DATA_W  sample word.
- post_trigger_count  input  32  samples to store after the trigger sample; latched on arm.
- write_allowed  input  1  trace RAM accepts a write this cycle.
- write_req  output  1  write request to trace RAM.
- writeSampleNumber  output  32  RAM address, zero-extended from ADDR_W.
- write_data  output  DATA_W  word to write.
- idle  output  1  FSM is in IDLE.
- triggered  output  1  trigger sample has been stored in the current capture.
- overrun  output  1  sticky; a sample was dropped because of backpressure. Cleared on arm.
- capture_valid  output  1  Begin/End describe a completed capture.
- sampleNumber_Begin  output  32  oldest stored sample number, zero-extended.
- sampleNumber_End  output  32  newest stored sample number, zero-extended.

Behaviour:
- Reset values:
  - state=IDLE, idle=1.
  - write_req=0, writeSampleNumber=0, write_data=0.
  - triggered=0, overrun=0, capture_valid=0.
  - Begin=0, End=0.
  - Internal wr_ptr=0, fill count=0, post counter=0, pend_trig=0.
- All outputs are registered. Reset takes priority over every other input.
- States:
  - IDLE -> PRETRIG on arm.
  - PRETRIG -> POSTTRIG when the trigger sample is accepted.
  - POSTTRIG -> IDLE when the post counter reaches 0 after an accepted write.
  - abort -> IDLE from any state.
- On arm:
  - wr_ptr=0, fill=0, post counter = post_trigger_count.
  - overrun=0, triggered=0, pend_trig=0, capture_valid=0.
  - A trigger in the arm cycle is ignored.
  - arm outside IDLE is ignored.
- Write handshake, in PRETRIG and POSTTRIG:
  - Output slot empty and sample_valid=1: load write_data=sample_data and writeSampleNumber=wr_ptr, and set write_req=1 next cycle.
  - The write completes in a cycle where write_req && write_allowed. On completion, wr_ptr increments modulo 2^ADDR_W and fill saturates at 2^ADDR_W.
  - The slot may reload in the same cycle the write completes: zero-bubble streaming.
  - sample_valid while the slot is full and not completing: the sample is dropped and overrun is set.
- Trigger qualification:
  - In PRETRIG, the trigger marks the sample loaded into the slot in that cycle.
  - If no sample is loaded in that cycle, pend_trig is set and marks the next loaded sample.
  - When that marked write completes: triggered=1 and state=POSTTRIG.
- POSTTRIG:
  - Each completed non-trigger write decrements the post counter.
  - With post_trigger_count=0, the FSM exits on the trigger write itself.
  - Trigger input is ignored.
- Completion, on entering IDLE via the count:
  - End = address of the last written sample.
  - Begin = 0 if fill < 2^ADDR_W, else (End+1) mod 2^ADDR_W.
  - capture_valid=1 and write_req=0 in the same update. idle rises in that same cycle.
  - Post-trigger samples may overwrite the trigger sample; no protection is provided.
- abort:
  - write_req drops next cycle; a pending slot is discarded.
  - capture_valid=0; Begin/End keep their old values.
- Readback contract: the window is inclusive. Begin > End means it wraps through 2^ADDR_W-1 to 0.

Decomposition:
- Package analyzer_pkg holds:
  - state enum: IDLE, PRETRIG, POSTTRIG.
  - ADDR_W/DATA_W defaults.
  - the wrap-increment function, shared with analyzerReadbackFSM.
- One sub-module, analyzer_write_slot: the single-entry output register implementing the write_req/write_allowed handshake and overrun detection. The FSM and pointers stay in the top.

Test Plan (ADDR_W=4 unless stated):
- Basic capture: arm, trigger on the 3rd valid sample, post=5, write_allowed=1 -> 8 writes at addresses 0..7; idle=1; Begin=0, End=7; capture_valid=1.
- Wrap: 20 samples before trigger, post=3 -> End=(trigger addr+3)&15; Begin=End+1 mod 16, giving Begin>End. Compare against the readback FSM, whose bench uses Begin 33554416 and End 19 with ADDR_W=25.
- Backpressure: write_allowed random, sample_valid every other cycle -> no drops, overrun=0, order preserved. sample_valid every cycle with write_allowed held low 2 cycles -> overrun=1 and exactly one sample missing.
- Pending trigger: trigger pulse with sample_valid=0 -> the next valid sample is the trigger write. Trigger in the arm cycle -> ignored.
- post=0 -> exit on the trigger write; Begin/End consistent.
- abort mid-POSTTRIG, then reset mid-PRETRIG -> abort gives idle=1, capture_valid=0, Begin/End unchanged; reset returns all outputs to their reset values on the next edge.
